// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master, slave and RAM: op encodings,
// master FSM states and the frame-length helper.
package spi_ram_pkg;

    // Command opcodes. The slave and RAM decode the same values.
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_t;

    // Master FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        TURN,
        RECV,
        GAP
    } state_t;

    // Frame body length in bits: two op bits followed by the payload.
    function automatic int frame_len(input int addr_size);
        return addr_size + 2;
    endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Command / read-return bundle between an upstream requester and the SPI RAM master.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
// The requester holds cmd_valid, cmd_op and cmd_payload stable until that edge.
// cmd_ready is high only while the master is idle. rd_valid is a one-cycle strobe
// with no back-pressure; rd_data holds its value until the next strobe.
interface spi_ram_master_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_SIZE-1:0] cmd_payload;
    logic [ADDR_SIZE-1:0] rd_data;
    logic                 rd_valid;
    logic                 busy;

    // Requester side.
    modport master (
        output cmd_valid, cmd_op, cmd_payload,
        input  cmd_ready, rd_data, rd_valid, busy
    );

    // SPI master side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_payload,
        output cmd_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_shift_reg.sv
// Parameterised shift register used both as PISO (frame transmit) and SIPO
// (read-data receive). Load has priority over shift; shifting moves towards the MSB.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    // Parallel load or one-bit left shift with serial_in entering at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/spi_ram_master.sv
// SPI RAM master: turns one accepted command into one SS_n-framed MOSI frame
// and, for RD_DATA, captures the returned byte from MISO.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE     = 8,
    parameter int RD_TURNAROUND = 2,
    parameter int IDLE_GAP      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_ram_master_if.slave     bus,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO,
    output state_t              fsm_state
);

    localparam int FRAME = frame_len(ADDR_SIZE);
    localparam int BW    = $clog2(FRAME);
    localparam int TW    = (RD_TURNAROUND > 1) ? $clog2(RD_TURNAROUND) : 1;
    localparam int GW    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    state_t               state_q, state_d;
    spi_op_t              op_q, op_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        turn_cnt_q, turn_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_SIZE-1:0] rd_data_q, rd_data_d;

    logic                 accept;
    logic                 tx_load, tx_shift, rx_shift;
    logic [FRAME-1:0]     tx_q;
    logic [ADDR_SIZE-1:0] rx_q;

    assign accept = bus.cmd_valid && cmd_ready_q;

    spi_shift_reg #(.WIDTH(FRAME)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .load_data ({bus.cmd_op, bus.cmd_payload}),
        .shift_en  (tx_shift),
        .serial_in (1'b0),
        .q         (tx_q)
    );

    spi_shift_reg #(.WIDTH(ADDR_SIZE)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (rx_shift),
        .serial_in (MISO),
        .q         (rx_q)
    );

    // Only the transmit MSB drives MOSI, and the receive MSB is superseded by
    // the bypassed shift on the final sample; the rest is intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{tx_q[FRAME-2:0], rx_q[ADDR_SIZE-1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each timed state leaves when its counter reaches zero.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = SEND;
            SEND:    if (bit_cnt_q == '0) state_d = (op_q == RD_DATA) ? TURN : GAP;
            TURN:    if (turn_cnt_q == '0) state_d = RECV;
            RECV:    if (bit_cnt_q == '0) state_d = GAP;
            GAP:     if (gap_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic: next values of every registered output and counter.
    always_comb begin
        op_d       = op_q;
        bit_cnt_d  = bit_cnt_q;
        turn_cnt_d = turn_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mosi_d     = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // The select bit leads the frame while the register loads.
                    op_d      = spi_op_t'(bus.cmd_op);
                    bit_cnt_d = BW'(FRAME - 1);
                    tx_load   = 1'b1;
                    mosi_d    = bus.cmd_op[1];
                end
            end
            START: begin
                mosi_d   = tx_q[FRAME-1];
                tx_shift = 1'b1;
            end
            SEND: begin
                if (bit_cnt_q != '0) begin
                    mosi_d    = tx_q[FRAME-1];
                    tx_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (op_q == RD_DATA) begin
                    turn_cnt_d = TW'(RD_TURNAROUND - 1);
                end else begin
                    gap_cnt_d = GW'(IDLE_GAP - 1);
                end
            end
            TURN: begin
                if (turn_cnt_q != '0) begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end else begin
                    bit_cnt_d = BW'(ADDR_SIZE - 1);
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else begin
                    // Include the final sample directly so rd_data is complete with the strobe.
                    rd_data_d  = {rx_q[ADDR_SIZE-2:0], MISO};
                    rd_valid_d = 1'b1;
                    gap_cnt_d  = GW'(IDLE_GAP - 1);
                end
            end
            GAP: begin
                if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: ;
        endcase
        ss_n_d      = (state_d == IDLE) || (state_d == GAP);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= WR_ADDR;
            bit_cnt_q   <= '0;
            turn_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            op_q        <= op_d;
            bit_cnt_q   <= bit_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: acts as requester and as the SPI slave + RAM,
// predicting frames and read data from a simple command-level RAM model.
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int AW       = 8;
  localparam int TURN     = 2;
  localparam int GAPC     = 1;
  localparam int FR       = AW + 2;
  localparam int WR_LEN   = FR + 1;             // SS_n-low cycles of a non-read frame
  localparam int RD_FIRST = WR_LEN + TURN + 1;  // first MISO sample cycle after acceptance
  localparam int RD_LEN   = RD_FIRST + AW - 1;  // last SS_n-low cycle of a read frame

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   MISO  = 1'b0;
  logic   SS_n;
  logic   MOSI;
  state_t fsm_state;

  spi_ram_master_if #(.ADDR_SIZE(AW)) bus ();

  spi_ram_master #(.ADDR_SIZE(AW), .RD_TURNAROUND(TURN), .IDLE_GAP(GAPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int            vectors     = 0;
  int            miscompares = 0;
  logic [7:0]    mem [256];
  logic [7:0]    waddr = '0;
  logic [7:0]    raddr = '0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the acceptance cycle.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] p);
    int waited;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_payload = p;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_within_bound", 32'(waited < 100), 32'd1);
  endtask

  // Observes the frame of a command accepted in the current cycle and acts as
  // the slave on MISO. With hold set, the next command is presented on the
  // first frame cycle with cmd_valid kept high.
  task automatic observe(input logic [1:0] op, input logic [AW-1:0] p, input bit hold,
                         input logic [1:0] nop, input logic [AW-1:0] np, output int ready_at);
    logic [FR:0]   got;
    logic [AW-1:0] rsp;
    logic [AW-1:0] rv_data;
    int            len, low_len, tail, busy_bad, ss_bad, rv_cnt, rv_at;
    bit            is_rd, in_low;

    is_rd = (op == RD_DATA);
    len   = is_rd ? RD_LEN : WR_LEN;
    rsp   = '0;
    case (op)
      WR_ADDR: waddr = p;
      WR_DATA: mem[waddr] = p;
      RD_ADDR: raddr = p;
      default: begin
        rsp = mem[raddr];
        exp_q.push_back(rsp);
      end
    endcase

    got = '0; low_len = 0; in_low = 1; tail = 0; busy_bad = 0; ss_bad = 0;
    rv_cnt = 0; rv_at = 0; rv_data = '0; ready_at = 0;
    for (int j = 1; j <= 60 && ready_at == 0; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (hold) begin
          bus.cmd_op      = nop;
          bus.cmd_payload = np;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      MISO = (is_rd && j >= RD_FIRST && j <= RD_LEN) ? rsp[RD_LEN - j] : 1'($urandom);
      if (in_low && SS_n === 1'b0) low_len++;
      else in_low = 0;
      if (j > len && SS_n !== 1'b1) ss_bad++;
      if (j <= WR_LEN) got = {got[FR-1:0], MOSI};
      else if (j <= len + 1 && MOSI !== 1'b0) tail++;
      if (bus.rd_valid === 1'b1) begin
        rv_cnt++;
        rv_at   = j;
        rv_data = bus.rd_data;
      end
      if (bus.cmd_ready === 1'b1) begin
        ready_at = j;
        if (bus.busy !== 1'b0) busy_bad++;
      end else if (bus.busy !== 1'b1) begin
        busy_bad++;
      end
    end

    check("ss_low_len", 32'(low_len), 32'(len));
    check("ss_high_after_frame", 32'(ss_bad), 32'd0);
    check("mosi_frame", 32'(got), 32'({op[1], op, p}));
    check("mosi_low_after_body", 32'(tail), 32'd0);
    check("ready_cycle", 32'(ready_at), 32'(len + 1 + GAPC));
    check("busy_window", 32'(busy_bad), 32'd0);
    if (is_rd) begin
      check("rd_valid_count", 32'(rv_cnt), 32'd1);
      check("rd_valid_cycle", 32'(rv_at), 32'(RD_LEN + 1));
      check("rd_data_strobe", 32'(rv_data), 32'(exp_q.pop_front()));
      last_rd = rsp;
    end else begin
      check("rd_valid_count", 32'(rv_cnt), 32'd0);
    end
    check("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
  endtask

  task automatic run(input logic [1:0] op, input logic [AW-1:0] p);
    int r;
    issue(op, p);
    observe(op, p, 1'b0, 2'b00, '0, r);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int r1, r2;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_payload = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // Write/read framing
    run(WR_ADDR, 8'h3C);
    run(WR_DATA, 8'hA5);
    run(RD_ADDR, 8'h3C);
    run(RD_DATA, 8'h00);
    check("rd_a5", 32'(bus.rd_data), 32'h000000A5);

    // Full write-then-read path
    run(WR_ADDR, 8'h10);
    run(WR_DATA, 8'h5A);
    run(RD_ADDR, 8'h10);
    run(RD_DATA, 8'h00);
    check("rd_5a", 32'(bus.rd_data), 32'h0000005A);

    run(WR_ADDR, 8'h77);
    run(WR_DATA, 8'hC3);
    run(RD_ADDR, 8'h77);
    run(RD_DATA, 8'h00);
    check("rd_c3", 32'(bus.rd_data), 32'h000000C3);

    // Second command held valid during a frame
    issue(WR_ADDR, 8'h22);
    observe(WR_ADDR, 8'h22, 1'b1, WR_DATA, 8'h99, r1);
    check("b2b_accept_after_rise", 32'(r1 - (WR_LEN + 1)), 32'(GAPC));
    observe(WR_DATA, 8'h99, 1'b1, RD_ADDR, 8'h22, r2);
    observe(RD_ADDR, 8'h22, 1'b1, RD_DATA, 8'h00, r2);
    observe(RD_DATA, 8'h00, 1'b0, 2'b00, '0, r2);
    check("rd_99", 32'(bus.rd_data), 32'h00000099);

    // Reset in the middle of a read frame
    issue(RD_DATA, 8'h00);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) bus.cmd_valid = 1'b0;
      MISO = 1'($urandom);
      if (j == 5) check("pre_reset_ss_low", 32'(SS_n), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_ss_n", 32'(SS_n), 32'd1);
    check("async_rst_mosi", 32'(MOSI), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_rd_data", 32'(bus.rd_data), 32'd0);
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", 32'(bus.cmd_ready), 32'd1);
    check("no_rd_valid_after_reset", 32'(bus.rd_valid), 32'd0);
    check("rd_data_after_reset", 32'(bus.rd_data), 32'd0);

    // Random commands
    for (int i = 0; i < 24; i++) begin
      run(2'($urandom_range(0, 3)), AW'($urandom_range(0, 255)));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
